// File: rtl/divider.sv
// Iterative restoring divider: one quotient bit per clock through a subtract-mode add.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude core + final sign fix).
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] remainder,
  output logic             zero_flag,
  output logic             exception_flag,
  output logic             overflow_flag
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] rem, rem_d;
  logic [WIDTH-1:0] quo, quo_d;
  logic [WIDTH-1:0] dvs, dvs_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             neg_q, neg_q_d, neg_r, neg_r_d, ovf, ovf_d;
  logic             busy_d, valid_d, zf_d, ef_d, of_d;
  logic [WIDTH-1:0] o_d, rout_d;

  // operand conditioning at latch time
  logic             a_neg, b_neg, ovf_in;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef DIV_SIGNED_EN
  assign a_neg  = i_1[WIDTH-1];
  assign b_neg  = i_2[WIDTH-1];
  assign ovf_in = (i_1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&i_2);
`else
  assign a_neg  = 1'b0;
  assign b_neg  = 1'b0;
  assign ovf_in = 1'b0;
`endif

  assign a_mag = a_neg ? (~i_1 + 1'b1) : i_1;
  assign b_mag = b_neg ? (~i_2 + 1'b1) : i_2;

  // one restoring step: shift {rem,quo}, trial-subtract the divisor as invert-and-add
  logic [WIDTH:0]   rem_sh, trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh + {1'b1, ~dvs} + {{WIDTH{1'b0}}, 1'b1};
  assign q_bit  = ~trial[WIDTH];
  assign rem_nx = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], q_bit};

  // sign fix: quotient truncates toward zero, remainder follows the dividend
  assign q_fin  = neg_q ? (~quo_nx + 1'b1) : quo_nx;
  assign r_fin  = neg_r ? (~rem_nx + 1'b1) : rem_nx;

  always_comb begin
    state_d = state;
    rem_d   = rem;
    quo_d   = quo;
    dvs_d   = dvs;
    cnt_d   = cnt;
    neg_q_d = neg_q;
    neg_r_d = neg_r;
    ovf_d   = ovf;
    busy_d  = busy;
    valid_d = 1'b0;
    o_d     = o;
    rout_d  = remainder;
    zf_d    = zero_flag;
    ef_d    = exception_flag;
    of_d    = overflow_flag;
    case (state)
      IDLE: begin
        if (start) begin
          if (i_2 == '0) begin
            o_d     = '1;
            rout_d  = i_1;
            zf_d    = 1'b0;
            ef_d    = 1'b1;
            of_d    = 1'b0;
            valid_d = 1'b1;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            cnt_d   = CW'(WIDTH);
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
            ovf_d   = ovf_in;
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          o_d     = q_fin;
          rout_d  = r_fin;
          zf_d    = (q_fin == '0);
          ef_d    = 1'b0;
          of_d    = ovf;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      cnt            <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      ovf            <= 1'b0;
      busy           <= 1'b0;
      valid          <= 1'b0;
      o              <= '0;
      remainder      <= '0;
      zero_flag      <= 1'b0;
      exception_flag <= 1'b0;
      overflow_flag  <= 1'b0;
    end else begin
      state          <= state_d;
      rem            <= rem_d;
      quo            <= quo_d;
      dvs            <= dvs_d;
      cnt            <= cnt_d;
      neg_q          <= neg_q_d;
      neg_r          <= neg_r_d;
      ovf            <= ovf_d;
      busy           <= busy_d;
      valid          <= valid_d;
      o              <= o_d;
      remainder      <= rout_d;
      zero_flag      <= zf_d;
      exception_flag <= ef_d;
      overflow_flag  <= of_d;
    end
  end

endmodule
